ahblite_cmd_master: RTL

AHBLITE_CMD_MASTER -- requirements
Module: ahblite_cmd_master

---
 rtl/ahblite_cmd_master.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ahblite_cmd_master.sv
// Single-outstanding AHB-Lite master: one cmd -> one NONSEQ transfer -> one rsp; optional stall timeout via AHB_MASTER_TIMEOUT_EN.
// Latency: accept to rsp_valid 3 cycles plus one per HREADY=0 cycle (1 cycle for rejected size/alignment); holds rsp until rsp_ready.
module ahblite_cmd_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic [1:0]  HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        write_q, err_q;
    logic [2:0]  size_q;
    logic        accept, misaligned, timeout, unused_hresp;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign unused_hresp = HRESP[1];
    assign cmd_ready    = (state == S_IDLE) && !HRESET;
    assign accept       = cmd_valid && cmd_ready;

    always_comb begin
        misaligned = 1'b0;
        case (cmd_size)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = cmd_addr[0];
            3'd2:    misaligned = |cmd_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of a phase.
    assign timeout = ((state == S_ADDR) || (state == S_DATA)) && !HREADY
                     && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK) begin
        if (HRESET)
            stall_cnt <= '0;
        else if (state != state_nxt)
            stall_cnt <= '0;
        else if (((state == S_ADDR) || (state == S_DATA)) && !HREADY)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = misaligned ? S_RESP : S_ADDR;
            S_ADDR: begin
                if (timeout)     state_nxt = S_RESP;
                else if (HREADY) state_nxt = S_DATA;
            end
            S_DATA: if (timeout || HREADY) state_nxt = S_RESP;
            S_RESP: if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                write_q <= cmd_write;
                size_q  <= cmd_size;
                wdata_q <= cmd_wdata;
            end
            // Response fields are zero outside RESP; read data only survives a clean read.
            if (accept && misaligned) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (state == S_DATA && HREADY) begin
                rdata_q <= (write_q || HRESP[0]) ? 32'h0 : HRDATA;
                err_q   <= HRESP[0];
            end else if (state == S_RESP && rsp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
    assign HADDR     = addr_q;
    assign HWRITE    = write_q;
    assign HSIZE     = size_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HWDATA    = (state == S_DATA && write_q) ? wdata_q : 32'h0;
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
